// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: default pattern,
// overlap-mode encodings and the fill-counter width helper.
package seq_detect_pkg;

   localparam logic [3:0] PAT_RST_DEFAULT = 4'b1011;

   localparam bit OVL_ON  = 1'b1;
   localparam bit OVL_OFF = 1'b0;

   // fill must be able to hold the value pat_w itself
   function automatic int fill_width(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// Up-counter that sticks at all ones; clr and rst both return it to zero.
module seq_detect_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: shifts valid bits into a history register and
// compares the newest PAT_W bits against a programmable masked pattern.
module seq_detect
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEFAULT),
   parameter int               CNT_W   = 8,
   parameter bit               OVERLAP = OVL_ON
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int FILL_W = fill_width(PAT_W);

   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-1:0]  mask_q, mask_d;
   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              match_q, match_d;

   logic [PAT_W-1:0]  cand;
   logic              hit;

   always_comb begin
      cand = {hist_q[PAT_W-2:0], in_bit};
      // clr and cfg_load outrank the data path, so a coincident bit never counts
      hit  = in_valid && !clr && !cfg_load
             && (fill_q >= FILL_W'(PAT_W - 1))
             && (((cand ^ pat_q) & mask_q) == '0);

      pat_d   = pat_q;
      mask_d  = mask_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;

      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (cfg_load) begin
         pat_d  = cfg_pattern;
         mask_d = cfg_mask;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d  = cand;
         match_d = hit;
         if (fill_q != FILL_W'(PAT_W)) begin
            fill_d = fill_q + FILL_W'(1);
         end
         if (hit && (OVERLAP == OVL_OFF)) begin
            fill_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q   <= PAT_RST;
         mask_q  <= '1;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         mask_q  <= mask_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   seq_detect_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (hit),
      .cnt (match_cnt)
   );

   assign match = match_q;

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus and are checked against a stream model.
module tb_seq_detect;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       cfg_load = 1'b0;
   logic [3:0] cfg_pattern = 4'h0;
   logic [3:0] cfg_mask = 4'h0;

   logic       match0, match1, match2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   seq_detect #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8), .OVERLAP(1'b1)) dut_ovl (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .match(match0), .match_cnt(cnt0));

   seq_detect #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8), .OVERLAP(1'b0)) dut_nov (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .match(match1), .match_cnt(cnt1));

   seq_detect #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .match(match2), .match_cnt(cnt2));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: every accepted bit goes into one stream; each instance remembers
   // where its eligible bits start. A hit needs 4 eligible bits whose newest
   // four agree with the pattern wherever the mask is set.
   localparam int CMAX [3] = '{255, 255, 3};
   localparam bit OVL  [3] = '{1'b1, 1'b0, 1'b1};

   bit         stream[$];
   int         start_i [3];
   int         cnt_m   [3];
   bit         match_m [3];
   logic [3:0] pat_m  = 4'b1011;
   logic [3:0] mask_m = 4'b1111;
   bit         model_ok = 1'b0;
   int         pulses  [3] = '{0, 0, 0};

   always @(posedge clk) begin
      if (rst) begin
         model_ok = 1'b1;
         pat_m    = 4'b1011;
         mask_m   = 4'b1111;
         for (int i = 0; i < 3; i++) begin
            start_i[i] = stream.size(); cnt_m[i] = 0; match_m[i] = 1'b0;
         end
      end else if (clr) begin
         for (int i = 0; i < 3; i++) begin
            start_i[i] = stream.size(); cnt_m[i] = 0; match_m[i] = 1'b0;
         end
      end else if (cfg_load) begin
         pat_m  = cfg_pattern;
         mask_m = cfg_mask;
         for (int i = 0; i < 3; i++) begin
            start_i[i] = stream.size(); match_m[i] = 1'b0;
         end
      end else if (in_valid) begin
         stream.push_back(in_bit);
         for (int i = 0; i < 3; i++) begin
            bit h;
            h = (stream.size() - start_i[i]) >= 4;
            if (h) begin
               for (int k = 0; k < 4; k++) begin
                  if (mask_m[k] && (stream[stream.size() - 1 - k] != pat_m[k])) h = 1'b0;
               end
            end
            match_m[i] = h;
            if (h) begin
               if (cnt_m[i] < CMAX[i]) cnt_m[i]++;
               if (!OVL[i]) start_i[i] = stream.size();
            end
         end
      end else begin
         for (int i = 0; i < 3; i++) match_m[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      #2;
      if (model_ok) begin
         chk($sformatf("match_ovl@%0t", $time), int'(match0), int'(match_m[0]));
         chk($sformatf("match_nov@%0t", $time), int'(match1), int'(match_m[1]));
         chk($sformatf("match_sat@%0t", $time), int'(match2), int'(match_m[2]));
         chk($sformatf("cnt_ovl@%0t", $time), int'(cnt0), cnt_m[0]);
         chk($sformatf("cnt_nov@%0t", $time), int'(cnt1), cnt_m[1]);
         chk($sformatf("cnt_sat@%0t", $time), int'(cnt2), cnt_m[2]);
         pulses[0] += int'(match0);
         pulses[1] += int'(match1);
         pulses[2] += int'(match2);
      end
   end

   task automatic drive(input logic r, input logic c, input logic l,
                        input logic [3:0] p, input logic [3:0] m,
                        input logic v, input logic b);
      @(negedge clk);
      rst = r; clr = c; cfg_load = l; cfg_pattern = p; cfg_mask = m;
      in_valid = v; in_bit = b;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic send_seq(input int n, input logic [31:0] bits);
      for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, bits[i]);
   endtask

   task automatic do_reset(input int n);
      repeat (n) drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(1);
      pulses = '{0, 0, 0};
   endtask

   initial begin
      // basic hit after a 5-cycle reset
      do_reset(5);
      chk("rst_match", int'(match0), 0);
      chk("rst_cnt", int'(cnt0), 0);
      send_seq(4, 32'b1011);
      idle(2);
      chk("t1_pulses", pulses[0], 1);
      chk("t1_cnt", int'(cnt0), 1);

      // overlap vs non-overlap on 1011011
      do_reset(1);
      send_seq(7, 32'b1011011);
      idle(2);
      chk("t2_ovl_pulses", pulses[0], 2);
      chk("t2_ovl_cnt", int'(cnt0), 2);
      chk("t2_nov_pulses", pulses[1], 1);
      chk("t2_nov_cnt", int'(cnt1), 1);

      // gaps in in_valid
      do_reset(1);
      send_seq(2, 32'b10);
      idle(3);
      send_seq(2, 32'b11);
      idle(2);
      chk("t3_pulses", pulses[0], 1);

      // reconfiguration; the bit coincident with cfg_load is dropped
      do_reset(1);
      drive(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1111, 1'b1, 1'b1);
      send_seq(4, 32'b0110);
      idle(2);
      chk("t4a_pulses", pulses[0], 1);
      pulses = '{0, 0, 0};
      drive(1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0);
      send_seq(4, 32'b1111);
      idle(2);
      chk("t4b_ovl_pulses", pulses[0], 1);
      chk("t4b_nov_pulses", pulses[1], 1);

      // saturation, then clr keeps the pattern
      do_reset(1);
      repeat (5) send_seq(4, 32'b1011);
      idle(2);
      chk("t5_sat_pulses", pulses[2], 5);
      chk("t5_sat_cnt", int'(cnt2), 3);
      chk("t5_ovl_cnt", int'(cnt0), 5);
      drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      idle(1);
      chk("t5_clr_cnt", int'(cnt2), 0);
      pulses = '{0, 0, 0};
      send_seq(4, 32'b1011);
      idle(2);
      chk("t5_post_clr_pulses", pulses[2], 1);
      chk("t5_post_clr_cnt", int'(cnt2), 1);

      // reset mid-stream discards partial history
      do_reset(1);
      send_seq(3, 32'b101);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      send_seq(1, 32'b1);
      idle(2);
      chk("t6_no_match", pulses[0], 0);
      send_seq(3, 32'b011);
      idle(2);
      chk("t6_match", pulses[0], 1);
      chk("t6_nov_match", pulses[1], 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
